uart_aes_stream_bridge: RTL

//  Streams bytes from uart_rx through a 128-bit AES core (top_encryption or top_decryption) and out to uart_tx, one block at a time.

---
 rtl/uart_aes_stream_bridge_if.sv | 23 ++
 rtl/uart_aes_stream_bridge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_aes_stream_bridge_if.sv
// uart_aes_stream_bridge_if: UART byte stream and AES engine handshakes seen by the bridge.
// master = bridge side, slave = the uart_rx/uart_tx/AES-core side.
interface uart_aes_stream_bridge_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_done;
    logic [127:0] eng_data_in;
    logic         eng_start;
    logic [127:0] eng_data_out;
    logic         eng_done;

    modport master (
        input  rx_data, rx_valid, tx_done, eng_data_out, eng_done,
        output tx_data, tx_start, eng_data_in, eng_start
    );

    modport slave (
        output rx_data, rx_valid, tx_done, eng_data_out, eng_done,
        input  tx_data, tx_start, eng_data_in, eng_start
    );
endinterface

// File: rtl/uart_aes_stream_bridge.sv
// uart_aes_stream_bridge: streams UART bytes through a 128-bit AES engine, one block in flight.
// Optional engine watchdog: define ENG_TIMEOUT_EN to add the err port, timeout counter and S_ERR.
module uart_aes_stream_bridge #(
    parameter int NUM_BLOCKS  = 4096,
    parameter int CNT_W       = 13,
    parameter int ENG_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_aes_stream_bridge_if.master bus,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
`ifdef ENG_TIMEOUT_EN
    output logic                     err,
`endif
    output logic [CNT_W-1:0]         blk_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_TXLD,
        S_TXW,
        S_NEXT
`ifdef ENG_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    localparam logic [CNT_W-1:0] LP_NUM_BLOCKS = CNT_W'(NUM_BLOCKS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [127:0]       r_in_buf;
    logic [3:0]         r_idx;
    logic               r_in_full;
    logic               r_overrun;
    logic [127:0]       r_eng_data_in;
    logic [127:0]       r_out_buf;
    logic [3:0]         r_ptr;
    logic [7:0]         r_tx_data;
    logic               r_tx_start;
    logic               r_eng_start;
    logic               r_done;
    logic [CNT_W-1:0]   r_blk_cnt;

    logic               w_consume;
    logic               w_rx_accept;
    logic               w_rx_drop;
    logic               w_eng_start_nxt;
    logic               w_cap_out;
    logic               w_tx_load;
    logic               w_ptr_inc;
    logic               w_blk_inc;
    logic               w_frame_end;

`ifdef ENG_TIMEOUT_EN
    localparam int               TMO_W       = $clog2(ENG_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] LP_TMO_LAST = TMO_W'(ENG_TIMEOUT - 1);

    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_err;
`endif

    // A byte arriving while the FSM empties the buffer is taken into slot 0 of the next block.
    assign w_consume   = (r_state == S_IDLE) && r_in_full;
    assign w_rx_accept = bus.rx_valid && (!r_in_full || w_consume);
    assign w_rx_drop   = bus.rx_valid && !w_rx_accept;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_nxt     = r_state;
        w_eng_start_nxt = 1'b0;
        w_cap_out       = 1'b0;
        w_tx_load       = 1'b0;
        w_ptr_inc       = 1'b0;
        w_blk_inc       = 1'b0;
        w_frame_end     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_in_full) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_eng_start_nxt = 1'b1;
                w_state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (bus.eng_done) begin
                    w_cap_out   = 1'b1;
                    w_state_nxt = S_TXLD;
                end
`ifdef ENG_TIMEOUT_EN
                else if (r_tmo_cnt == LP_TMO_LAST) begin
                    w_state_nxt = S_ERR;
                end
`endif
            end
            S_TXLD: begin
                w_tx_load   = 1'b1;
                w_state_nxt = S_TXW;
            end
            S_TXW: begin
                if (bus.tx_done) begin
                    if (r_ptr != 4'd15) begin
                        w_ptr_inc   = 1'b1;
                        w_state_nxt = S_TXLD;
                    end else begin
                        w_blk_inc   = 1'b1;
                        w_state_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                w_frame_end = (r_blk_cnt == LP_NUM_BLOCKS);
                w_state_nxt = S_IDLE;
            end
`ifdef ENG_TIMEOUT_EN
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: block buffers carry no reset; r_in_full and the FSM state say when their contents matter.
    always_ff @(posedge clk) begin
        if (w_rx_accept) begin
            r_in_buf[{r_idx, 3'b000} +: 8] <= bus.rx_data;
        end
        if (w_cap_out) begin
            r_out_buf <= bus.eng_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= 4'd0;
            r_in_full     <= 1'b0;
            r_overrun     <= 1'b0;
            r_eng_data_in <= '0;
            r_ptr         <= 4'd0;
            r_tx_data     <= 8'd0;
            r_tx_start    <= 1'b0;
            r_eng_start   <= 1'b0;
            r_done        <= 1'b0;
            r_blk_cnt     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_eng_start <= w_eng_start_nxt;
            r_tx_start  <= w_tx_load;
            r_done      <= w_frame_end;
            r_overrun   <= r_overrun | w_rx_drop;
            r_in_full   <= (w_rx_accept && (r_idx == 4'd15)) || (r_in_full && !w_consume);
            if (w_rx_accept) begin
                r_idx <= r_idx + 4'd1;
            end
            // NOTE: non-blocking assignment lets this copy see the buffer before this cycle's slot-0 write.
            if (w_consume) begin
                r_eng_data_in <= r_in_buf;
            end
            if (w_cap_out) begin
                r_ptr <= 4'd0;
            end else if (w_ptr_inc) begin
                r_ptr <= r_ptr + 4'd1;
            end
            if (w_tx_load) begin
                r_tx_data <= r_out_buf[{r_ptr, 3'b000} +: 8];
            end
            if (w_frame_end) begin
                r_blk_cnt <= '0;
            end else if (w_blk_inc) begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

`ifdef ENG_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_state_nxt == S_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign overrun         = r_overrun;
    assign blk_cnt         = r_blk_cnt;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_start    = r_tx_start;
    assign bus.eng_data_in = r_eng_data_in;
    assign bus.eng_start   = r_eng_start;

endmodule
